// File: rtl/hazard_forward_ctrl.sv
// Purpose : load-use hazard detection, registered ALU-operand forwarding selects and a stall counter.
// Latency : stall/pc_write/ifid_write/idex_flush are combinational; fwd_a/fwd_b update one edge later.
// Backpr. : stall holds PC and IF/ID and bubbles ID/EX; the EX->MEM tracking never freezes.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_rs/id_rt           source fields of the instruction in ID, with id_uses_rs/id_uses_rt
//   ex_reg_dest           destination picked by the EX destination mux (rt or rd)
//   ex_reg_write          EX instruction writes the register file
//   ex_mem_read           EX instruction is a load
//   pc_write, ifid_write  enables, low while stalling
//   idex_flush            zero the ID/EX control word (bubble)
//   fwd_a, fwd_b          00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write data
//   stall_count           saturating count of stall cycles since reset
module hazard_forward_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] ex_reg_dest,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b10;
   localparam logic [1:0] FWD_MEM = 2'b01;

   logic [REG_W-1:0] mem_dest;
   logic             mem_reg_write;
   logic             stall;
   logic             ex_dest_nz;
   logic             mem_dest_nz;
   logic [1:0]       fwd_a_nxt;
   logic [1:0]       fwd_b_nxt;

   assign ex_dest_nz  = (ex_reg_dest != '0);
   assign mem_dest_nz = (mem_dest != '0);

   // Only a load in EX can stall: its data is not ready until the end of MEM.
   assign stall = ex_mem_read & ex_reg_write & ex_dest_nz &
                  ((id_uses_rs & (ex_reg_dest == id_rs)) |
                   (id_uses_rt & (ex_reg_dest == id_rt)));

   assign pc_write   = ~stall;
   assign ifid_write = ~stall;
   assign idex_flush = stall;

   // EX match is checked first: the younger producer holds the current value.
   // A load in EX is excluded because its result only exists once it reaches MEM/WB.
   always_comb begin
      fwd_a_nxt = FWD_RF;
      fwd_b_nxt = FWD_RF;
      if (!stall) begin
         if (id_uses_rs && ex_reg_write && !ex_mem_read && ex_dest_nz && (ex_reg_dest == id_rs))
            fwd_a_nxt = FWD_EX;
         else if (id_uses_rs && mem_reg_write && mem_dest_nz && (mem_dest == id_rs))
            fwd_a_nxt = FWD_MEM;

         if (id_uses_rt && ex_reg_write && !ex_mem_read && ex_dest_nz && (ex_reg_dest == id_rt))
            fwd_b_nxt = FWD_EX;
         else if (id_uses_rt && mem_reg_write && mem_dest_nz && (mem_dest == id_rt))
            fwd_b_nxt = FWD_MEM;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_dest      <= '0;
         mem_reg_write <= 1'b0;
         fwd_a         <= FWD_RF;
         fwd_b         <= FWD_RF;
         stall_count   <= '0;
      end else begin
         mem_dest      <= ex_reg_dest;
         mem_reg_write <= ex_reg_write;
         fwd_a         <= fwd_a_nxt;
         fwd_b         <= fwd_b_nxt;
         if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Purpose : self-checking bench for hazard_forward_ctrl with a behavioural pipeline model.
// Latency : model updates forwarding selects and counter once per rising edge.
// Backpr. : n/a (bench drives every input directly).
module tb_hazard_forward_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 3;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [REG_W-1:0] id_rs, id_rt, ex_reg_dest;
   logic             id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
   logic             pc_write, ifid_write, idex_flush;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: what sits in MEM, and the expected registered outputs
   int m_mem_dest;
   bit m_mem_wr;
   int m_fa, m_fb;
   int m_cnt;

   hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_reg_dest(ex_reg_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_flush(idex_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit m_stall();
      int d = int'(ex_reg_dest);
      return ex_mem_read && ex_reg_write && d != 0 &&
             ((id_uses_rs && d == int'(id_rs)) || (id_uses_rt && d == int'(id_rt)));
   endfunction

   // Where a consumer of register r finds its value next cycle.
   function automatic int m_source(input bit uses, input int r);
      if (!uses || r == 0)                                           return 0;
      if (ex_reg_write && !ex_mem_read && int'(ex_reg_dest) == r)    return 2;
      if (m_mem_wr && m_mem_dest == r)                               return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_mem_dest = 0; m_mem_wr = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      bit s = m_stall();
      m_fa = s ? 0 : m_source(id_uses_rs, int'(id_rs));
      m_fb = s ? 0 : m_source(id_uses_rt, int'(id_rt));
      m_mem_dest = int'(ex_reg_dest);
      m_mem_wr   = ex_reg_write;
      if (s && m_cnt < SAT) m_cnt++;
   endtask

   task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                        input int ed, input bit ew, input bit emr);
      id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_uses_rs = urs; id_uses_rt = urt;
      ex_reg_dest = REG_W'(ed); ex_reg_write = ew; ex_mem_read = emr;
   endtask

   task automatic check_comb(input string tag);
      bit s;
      #1;
      s = m_stall();
      check({tag, ".pc_write"},   pc_write,   !s);
      check({tag, ".ifid_write"}, ifid_write, !s);
      check({tag, ".idex_flush"}, idex_flush, s);
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".fwd_a"},       fwd_a,       m_fa);
      check({tag, ".fwd_b"},       fwd_b,       m_fb);
      check({tag, ".stall_count"}, stall_count, m_cnt);
   endtask

   // one pipeline cycle: combinational check, edge, then registered check
   task automatic cycle(input string tag);
      check_comb(tag);
      @(posedge clk);
      model_edge();
      #1;
      check_regs(tag);
   endtask

   initial begin
      // reset with random inputs
      reset = 1'b1;
      drive($urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom), 1'($urandom),
            $urandom_range(0, 31), 1'($urandom), 1'($urandom));
      model_reset();
      #2;
      check("rst.fwd_a", fwd_a, 0);
      check("rst.fwd_b", fwd_b, 0);
      check("rst.stall_count", stall_count, 0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rel.pc_write", pc_write, 1);
      check("rel.ifid_write", ifid_write, 1);
      check("rel.idex_flush", idex_flush, 0);
      cycle("idle");

      // EX forward
      drive(8, 0, 1, 0, 8, 1, 0);
      cycle("exfwd");
      check("exfwd.fwd_a_const", fwd_a, 2);
      check("exfwd.fwd_b_const", fwd_b, 0);

      // MEM forward and EX-over-MEM priority
      drive(0, 0, 0, 0, 9, 1, 0);  cycle("memfwd0");
      drive(9, 10, 1, 1, 10, 1, 0); cycle("memfwd1");
      check("memfwd.fwd_a_const", fwd_a, 1);
      check("memfwd.fwd_b_const", fwd_b, 2);
      drive(0, 0, 0, 0, 9, 1, 0);  cycle("prio0");
      drive(9, 10, 1, 1, 9, 1, 0);  cycle("prio1");
      check("prio.fwd_a_const", fwd_a, 2);

      // load-use: one stall, then MEM forward after the bubble
      drive(0, 0, 0, 0, 0, 0, 0); cycle("lu_clear");
      drive(0, 5, 0, 1, 5, 1, 1);
      #1;
      check("lu.pc_write_const", pc_write, 0);
      check("lu.ifid_write_const", ifid_write, 0);
      check("lu.idex_flush_const", idex_flush, 1);
      cycle("lu_stall");
      check("lu.fwd_b_const", fwd_b, 0);
      check("lu.stall_count_const", stall_count, 1);
      drive(0, 5, 0, 1, 0, 0, 0);
      #1;
      check("lu_bubble.idex_flush_const", idex_flush, 0);
      cycle("lu_bubble");
      check("lu_after.fwd_b_const", fwd_b, 1);

      // register 0 and unused operand
      drive(0, 0, 1, 0, 0, 1, 1); cycle("r0");
      check("r0.fwd_a_const", fwd_a, 0);
      drive(6, 0, 0, 0, 6, 1, 1); cycle("unused");
      check("unused.fwd_a_const", fwd_a, 0);

      // random traffic on a small register set so hazards are frequent
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom));
         cycle("rand");
      end

      // saturation, then asynchronous reset mid-stall
      reset = 1'b1; model_reset(); #1;
      reset = 1'b0;
      drive(0, 5, 0, 1, 5, 1, 1);
      for (int i = 0; i < 10; i++) cycle("sat");
      check("sat.stall_count_const", stall_count, SAT);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("midrst.stall_count", stall_count, 0);
      check("midrst.fwd_b", fwd_b, 0);
      check("midrst.idex_flush", idex_flush, 1);
      @(negedge clk);
      reset = 1'b0;
      drive(5, 0, 1, 0, 0, 0, 0);
      cycle("postrst");
      check("postrst.fwd_a_const", fwd_a, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Tracks the destination register chosen by the EX-stage destination mux (rt for I-type, rd for R-type) as it moves EX -> MEM.
- Detects load-use hazards for the instruction in ID, stalls IF/ID and inserts an ID/EX bubble.
- Produces registered ALU-operand forwarding selects for the instruction entering EX, and keeps a saturating stall counter for performance reporting.

Parameters:
- REG_W, 5, register-index width
- CNT_W, 16, stall counter width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_rs  input  REG_W  rs field of the instruction in ID
- id_rt  input  REG_W  rt field of the instruction in ID
- id_uses_rs  input  1  instruction in ID reads rs
- id_uses_rt  input  1  instruction in ID reads rt
- ex_reg_dest  input  REG_W  selected destination of the instruction in EX (output of the EX destination mux)
- ex_reg_write  input  1  instruction in EX writes the register file
- ex_mem_read  input  1  instruction in EX is a load
- pc_write  output  1  PC update enable (0 = hold)
- ifid_write  output  1  IF/ID register enable (0 = hold)
- idex_flush  output  1  force ID/EX control signals to zero (bubble)
- fwd_a  output  2  operand-A select in EX: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write data
- fwd_b  output  2  operand-B select, same encoding
- stall_count  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Reset (async, active-high): fwd_a = fwd_b = 00, mem_dest = 0, mem_reg_write = 0, stall_count = 0. Combinational outputs follow their equations; with inputs at 0: pc_write = 1, ifid_write = 1, idex_flush = 0.
- Internal MEM-stage tracking, every rising edge: mem_dest <= ex_reg_dest; mem_reg_write <= ex_reg_write. The EX->MEM pipeline never freezes, so these update regardless of stall.
- Register 0 is never a hazard. Every match below requires the compared destination != 0.
- Load-use stall (combinational, same cycle):
  - stall = ex_mem_read & ex_reg_write & ex_reg_dest != 0 & ((id_uses_rs & ex_reg_dest == id_rs) | (id_uses_rt & ex_reg_dest == id_rt)).
  - pc_write = ifid_write = ~stall; idex_flush = stall.
  - A load-use hazard always costs exactly one stall cycle. In the next cycle the load sits in MEM, and the stall term, which depends only on the EX stage, clears unless a new load is in EX.
- Forwarding (registered; one-cycle latency, aligned with the ID->EX transfer):
  - Computed per operand X in {rs -> fwd_a, rt -> fwd_b}.
  - At each edge:
    - if stall: fwd_X <= 00, because the bubble carries no operands.
    - elif uses_X & ex_reg_write & ~ex_mem_read & ex_reg_dest != 0 & ex_reg_dest == id_X: fwd_X <= 10.
    - elif uses_X & mem_reg_write & mem_dest != 0 & mem_dest == id_X: fwd_X <= 01.
    - else: fwd_X <= 00.
  - Priority: the EX match (the younger producer) wins over the MEM match when both name the same register.
  - After a load-use stall, the load is in MEM, so the consumer receives fwd = 01.
- No WB-stage forwarding. The register file writes in the first half-cycle and reads in the second, so a WB producer is seen by the ID read directly.
- stall_count: increments by 1 on each edge where stall = 1. Holds at 2^CNT_W - 1 (no wrap).
- Reset asserted mid-stall: outputs return immediately to their reset values. The tracking registers clear, so no forwarding is derived from pre-reset instructions.

Test Plan:
- Reset: assert reset with random inputs -> fwd_a = fwd_b = 00, stall_count = 0; after release with all inputs 0, pc_write = 1, ifid_write = 1, idex_flush = 0.
- EX forward: ex_reg_dest = 8, ex_reg_write = 1, ex_mem_read = 0, id_rs = 8, id_uses_rs = 1, one edge -> fwd_a = 10, fwd_b = 00, no stall.
- MEM forward with priority:
  - Cycle n: EX dest = 9, write = 1. Cycle n+1: EX dest = 10, write = 1; ID rs = 9, rt = 10, both used. Edge -> fwd_a = 01, fwd_b = 10.
  - Repeat with EX dest = 9 in both cycles -> fwd_a = 10.
- Load-use: ex_mem_read = 1, ex_reg_write = 1, ex_reg_dest = 5, id_rt = 5, id_uses_rt = 1 -> same cycle pc_write = 0, ifid_write = 0, idex_flush = 1. Next edge: fwd_b = 00, stall_count = 1. Drive EX as the bubble (write = 0) while ID holds -> stall = 0, and the following edge gives fwd_b = 01.
- Register 0 and unused operands: ex_reg_dest = 0 with a load and id_rs = 0 -> no stall, fwd_a = 00. Dest match with id_uses_rs = 0 -> no stall, fwd_a = 00.
- Saturation: CNT_W = 3, hold the load-use condition for 10 cycles -> stall_count reaches 7 and stays 7. Asserting reset mid-stall clears it to 0 asynchronously.
